// File: rtl/hpi_pkg.sv
// Shared types and constants for the EZ-OTG HPI bus engine.
package hpi_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RECOVER
  } hpi_state_e;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

endpackage

// File: rtl/hpi_sync2.sv
// Two-flop synchroniser for asynchronous chip inputs into the clk domain.
module hpi_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/otg_hpi_bus_engine.sv
// Avalon-MM slave that runs timed CY7C67200 HPI pin cycles and syncs the OTG irq.
//   state   | meaning
//   IDLE    | waiting for an Avalon request
//   SETUP   | cs_n low, address (and write data) settling
//   STROBE  | rd_n or wr_n low
//   HOLD    | strobe released, cs_n/addr/data held; last cycle ends the transfer
//   RECOVER | cs_n high, bus turnaround before the next access
module otg_hpi_bus_engine
  import hpi_pkg::*;
#(
  parameter int SETUP_CYC    = 1,
  parameter int STROBE_CYC   = 6,
  parameter int HOLD_CYC     = 2,
  parameter int RECOVERY_CYC = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_chipselect,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [15:0] avs_writedata,
  output logic [15:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic [1:0]  otg_addr,
  output logic        otg_cs_n,
  output logic        otg_rd_n,
  output logic        otg_wr_n,
  output logic [15:0] otg_data_out,
  output logic        otg_data_oe,
  input  logic [15:0] otg_data_in,
  input  logic        otg_int,
  output logic        irq
);

  // Counters run from N-1 down to 0, so 0 marks the last cycle of a state.
  localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'((SETUP_CYC    > 0) ? SETUP_CYC    - 1 : 0);
  localparam logic [CNT_W-1:0] STROBE_LD  = CNT_W'((STROBE_CYC   > 0) ? STROBE_CYC   - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'((HOLD_CYC     > 0) ? HOLD_CYC     - 1 : 0);
  localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'((RECOVERY_CYC > 0) ? RECOVERY_CYC - 1 : 0);

  hpi_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wr_q;
  logic [1:0]       addr_q;
  logic             cs_n_q;
  logic             rd_n_q;
  logic             wr_n_q;
  logic [15:0]      data_out_q;
  logic             oe_q;
  logic [15:0]      readdata_q;
  logic             req;
  logic             cnt_last;

  assign req      = avs_chipselect & (avs_read | avs_write);
  assign cnt_last = (cnt_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      data_out_q <= '0;
      oe_q       <= 1'b0;
      readdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            wr_q   <= avs_write;
            addr_q <= avs_address;
            cs_n_q <= 1'b0;
            oe_q   <= avs_write;
            if (avs_write) data_out_q <= avs_writedata;
            if (SETUP_CYC == 0) begin
              state_q <= STROBE;
              cnt_q   <= STROBE_LD;
              rd_n_q  <= avs_write;
              wr_n_q  <= ~avs_write;
            end else begin
              state_q <= SETUP;
              cnt_q   <= SETUP_LD;
            end
          end
        end
        SETUP: begin
          if (cnt_last) begin
            state_q <= STROBE;
            cnt_q   <= STROBE_LD;
            rd_n_q  <= wr_q;
            wr_n_q  <= ~wr_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        STROBE: begin
          if (cnt_last) begin
            state_q <= HOLD;
            cnt_q   <= HOLD_LD;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            if (!wr_q) readdata_q <= otg_data_in;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt_last) begin
            cs_n_q <= 1'b1;
            oe_q   <= 1'b0;
            if (RECOVERY_CYC == 0) begin
              state_q <= IDLE;
            end else begin
              state_q <= RECOVER;
              cnt_q   <= RECOVER_LD;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RECOVER: begin
          if (cnt_last) state_q <= IDLE;
          else          cnt_q   <= cnt_q - CNT_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The only cycle the master is released is the final HOLD cycle.
  assign avs_waitrequest = req & ~((state_q == HOLD) & cnt_last);

  assign avs_readdata = readdata_q;
  assign otg_addr     = addr_q;
  assign otg_cs_n     = cs_n_q;
  assign otg_rd_n     = rd_n_q;
  assign otg_wr_n     = wr_n_q;
  assign otg_data_out = data_out_q;
  assign otg_data_oe  = oe_q;

  hpi_sync2 #(.WIDTH(1)) u_int_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (otg_int),
    .q_o     (irq)
  );

endmodule

// File: tb/tb_otg_hpi_bus_engine.sv
// Directed scoreboard bench for the HPI bus engine, default and zero-setup/recovery builds.
module tb_otg_hpi_bus_engine;
  import hpi_pkg::*;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] din;
  } acc_t;

  typedef struct packed {
    logic [1:0]  addr;
    logic        chk_wdata;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  avs_address;
  logic        avs_chipselect, avs_read, avs_write;
  logic [15:0] avs_writedata, otg_data_in;
  logic        otg_int;

  logic [15:0] a_readdata, b_readdata, a_data_out, b_data_out;
  logic [1:0]  a_addr, b_addr;
  logic        a_wait, b_wait, a_cs_n, b_cs_n, a_rd_n, b_rd_n, a_wr_n, b_wr_n;
  logic        a_oe, b_oe, a_irq, b_irq;

  logic        sel;
  logic [15:0] p_readdata, p_data_out;
  logic [1:0]  p_addr;
  logic        p_wait, p_cs_n, p_rd_n, p_wr_n, p_oe, p_irq;

  acc_t        stim_q[$];
  exp_t        exp_q[$];
  logic [15:0] last_rd;
  logic [31:0] cs_m, wr_m, rd_m, oe_m, wt_m;
  logic [15:0] rdd [32];
  logic        viol;
  int          ncmp = 0;
  int          nfail = 0;

  always #5 clk = ~clk;

  otg_hpi_bus_engine dut_a (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_chipselect(avs_chipselect),
    .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_readdata(a_readdata), .avs_waitrequest(a_wait), .otg_addr(a_addr), .otg_cs_n(a_cs_n),
    .otg_rd_n(a_rd_n), .otg_wr_n(a_wr_n), .otg_data_out(a_data_out), .otg_data_oe(a_oe),
    .otg_data_in(otg_data_in), .otg_int(otg_int), .irq(a_irq)
  );

  otg_hpi_bus_engine #(.SETUP_CYC(0), .RECOVERY_CYC(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_chipselect(avs_chipselect),
    .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_readdata(b_readdata), .avs_waitrequest(b_wait), .otg_addr(b_addr), .otg_cs_n(b_cs_n),
    .otg_rd_n(b_rd_n), .otg_wr_n(b_wr_n), .otg_data_out(b_data_out), .otg_data_oe(b_oe),
    .otg_data_in(otg_data_in), .otg_int(otg_int), .irq(b_irq)
  );

  assign p_readdata = sel ? b_readdata : a_readdata;
  assign p_data_out = sel ? b_data_out : a_data_out;
  assign p_addr     = sel ? b_addr     : a_addr;
  assign p_wait     = sel ? b_wait     : a_wait;
  assign p_cs_n     = sel ? b_cs_n     : a_cs_n;
  assign p_rd_n     = sel ? b_rd_n     : a_rd_n;
  assign p_wr_n     = sel ? b_wr_n     : a_wr_n;
  assign p_oe       = sel ? b_oe       : a_oe;
  assign p_irq      = sel ? b_irq      : a_irq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int lo, input int hi);
    logic [31:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic bus_idle();
    avs_chipselect = 1'b0;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
  endtask

  task automatic present(input acc_t a);
    avs_chipselect = 1'b1;
    avs_read       = a.rd;
    avs_write      = a.wr;
    avs_address    = a.addr;
    avs_writedata  = a.wdata;
    otg_data_in    = a.din;
  endtask

  // Push stimulus and its expected completion; writes leave readdata at the last read value.
  task automatic push_acc(input logic wr, input logic rd, input logic [1:0] addr,
                          input logic [15:0] wdata, input logic [15:0] din);
    exp_t e;
    stim_q.push_back('{wr: wr, rd: rd, addr: addr, wdata: wdata, din: din});
    if (!wr) last_rd = din;
    e.addr      = addr;
    e.chk_wdata = wr;
    e.wdata     = wdata;
    e.rdata     = last_rd;
    exp_q.push_back(e);
  endtask

  // T0 is the cycle the first queued request is presented; pins are sampled on negedges.
  task automatic run_seq(input int ncyc);
    logic active, done;
    exp_t e;
    acc_t a;
    cs_m = '0; wr_m = '0; rd_m = '0; oe_m = '0; wt_m = '0; viol = 1'b0;
    @(posedge clk); #1;
    active = 1'b0;
    if (stim_q.size() > 0) begin
      a = stim_q.pop_front();
      present(a);
      active = 1'b1;
    end
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      done    = 1'b0;
      cs_m[k] = ~p_cs_n;
      wr_m[k] = ~p_wr_n;
      rd_m[k] = ~p_rd_n;
      oe_m[k] = p_oe;
      rdd[k]  = p_readdata;
      if ((!p_rd_n && !p_wr_n) || (p_oe && !p_rd_n)) viol = 1'b1;
      if (active && !p_wait) begin
        wt_m[k] = 1'b1;
        done    = 1'b1;
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("cpl_addr", 32'(p_addr), 32'(e.addr));
          if (e.chk_wdata) check("cpl_wdata", 32'(p_data_out), 32'(e.wdata));
          check("cpl_rdata", 32'(p_readdata), 32'(e.rdata));
        end
      end
      @(posedge clk); #1;
      if (done) begin
        if (stim_q.size() > 0) begin
          a = stim_q.pop_front();
          present(a);
        end else begin
          bus_idle();
          active = 1'b0;
        end
      end
    end
    bus_idle();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("bus_rules", 32'(viol), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    last_rd = '0;
    bus_idle();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    sel = 1'b0;
    avs_address = '0; avs_writedata = '0; otg_data_in = '0; otg_int = 1'b0;
    bus_idle();
    reset_n = 1'b0;
    last_rd = '0;
    #12;
    check("rst_cs_n", 32'(a_cs_n), 32'd1);
    check("rst_rd_n", 32'(a_rd_n), 32'd1);
    check("rst_wr_n", 32'(a_wr_n), 32'd1);
    check("rst_addr", 32'(a_addr), 32'd0);
    check("rst_dout", 32'(a_data_out), 32'd0);
    check("rst_oe", 32'(a_oe), 32'd0);
    check("rst_rdata", 32'(a_readdata), 32'd0);
    check("rst_irq", 32'(a_irq), 32'd0);
    check("rst_wait", 32'(a_wait), 32'd0);
    do_reset();

    // Default-timing write.
    push_acc(1'b1, 1'b0, HPI_ADDRESS, 16'h1234, 16'h0000);
    run_seq(16);
    check("wr_cs", cs_m, mk(1, 9));
    check("wr_wr", wr_m, mk(2, 7));
    check("wr_rd", rd_m, 32'd0);
    check("wr_oe", oe_m, mk(1, 9));
    check("wr_wait", wt_m, 32'h200);

    // Default-timing read.
    push_acc(1'b0, 1'b1, HPI_DATA, 16'h0000, 16'hBEEF);
    run_seq(16);
    check("rd_cs", cs_m, mk(1, 9));
    check("rd_rd", rd_m, mk(2, 7));
    check("rd_wr", wr_m, 32'd0);
    check("rd_oe", oe_m, 32'd0);
    check("rd_wait", wt_m, 32'h200);
    check("rd_t7_old", 32'(rdd[7]), 32'h0000);
    check("rd_t8", 32'(rdd[8]), 32'hBEEF);

    // Read and write together resolve as a write.
    push_acc(1'b1, 1'b1, HPI_MAILBOX, 16'h00AA, 16'h7777);
    run_seq(16);
    check("rw_wr", wr_m, mk(2, 7));
    check("rw_rd", rd_m, 32'd0);

    // Back-to-back write then read.
    push_acc(1'b1, 1'b0, HPI_STATUS, 16'h5555, 16'h0000);
    push_acc(1'b0, 1'b1, HPI_DATA, 16'h0000, 16'h5A5A);
    run_seq(28);
    check("b2b_cs", cs_m, mk(1, 9) | mk(15, 23));
    check("b2b_wr", wr_m, mk(2, 7));
    check("b2b_rd", rd_m, mk(16, 21));
    check("b2b_wait", wt_m, 32'h0080_0200);

    // Reset in the middle of a write strobe.
    @(posedge clk); #1;
    present('{wr: 1'b1, rd: 1'b0, addr: HPI_ADDRESS, wdata: 16'h4321, din: 16'h0000});
    repeat (4) @(posedge clk);
    #2;
    check("mid_wr_low", 32'(a_wr_n), 32'd0);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_cs", 32'(a_cs_n), 32'd1);
    check("mid_rst_wr", 32'(a_wr_n), 32'd1);
    check("mid_rst_oe", 32'(a_oe), 32'd0);
    check("mid_rst_rdata", 32'(a_readdata), 32'd0);
    bus_idle();
    last_rd = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_state", 32'(dut_a.state_q), 32'(IDLE));
    push_acc(1'b0, 1'b1, HPI_DATA, 16'h0000, 16'h1357);
    run_seq(16);
    check("post_rst_cs", cs_m, mk(1, 9));
    check("post_rst_rd", rd_m, mk(2, 7));

    // Zero setup / zero recovery build.
    sel = 1'b1;
    do_reset();
    push_acc(1'b1, 1'b0, HPI_STATUS, 16'h0F0F, 16'h0000);
    push_acc(1'b1, 1'b0, HPI_DATA, 16'h1111, 16'h0000);
    run_seq(20);
    check("z_cs", cs_m, mk(1, 8) | mk(10, 17));
    check("z_wr", wr_m, mk(1, 6) | mk(10, 15));
    check("z_oe", oe_m, mk(1, 8) | mk(10, 17));
    check("z_wait", wt_m, 32'h0002_0100);

    // Interrupt synchroniser latency.
    @(posedge clk); #1 otg_int = 1'b1;
    @(posedge clk); @(negedge clk);
    check("irq_rise_1", 32'(p_irq), 32'd0);
    @(posedge clk); @(negedge clk);
    check("irq_rise_2", 32'(p_irq), 32'd1);
    @(posedge clk); #1 otg_int = 1'b0;
    @(posedge clk); @(negedge clk);
    check("irq_fall_1", 32'(p_irq), 32'd1);
    @(posedge clk); @(negedge clk);
    check("irq_fall_2", 32'(p_irq), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
